bram_dp_clr: RTL and testbench



---
 rtl/bram_pkg.sv | 18 +
 rtl/bram_dp_clr_if.sv | 29 ++
 rtl/bram_dp_core.sv | 26 ++
 rtl/bram_dp_clr.sv | 127 ++++++++++++
 tb/tb_bram_dp_clr.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/bram_pkg.sv
// bram_pkg: shared types and constants for bram_dp_clr and its consumers.
// Optional feature macro: BRAM_OUTREG_EN (second output register stage).
package bram_pkg;

  // Clear engine owns the array in ST_CLEAR; the user owns it in ST_READY.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Read latency in clock edges, so downstream pipelines can align to it.
`ifdef BRAM_OUTREG_EN
  localparam int BRAM_RD_LAT = 2;
`else
  localparam int BRAM_RD_LAT = 1;
`endif

endpackage

// File: rtl/bram_dp_clr_if.sv
// bram_dp_clr_if: user-side bus of the dual-port clearable RAM.
// Handshake: there is no backpressure; wr_en is accepted on any edge where
// busy is low (and rst is low), and ignored otherwise. Reads are always accepted.
interface bram_dp_clr_if
  import bram_pkg::*;
#(
  parameter int DW = 18,
  parameter int AW = 7
);
  logic          clr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] wr_din;
  logic [DW-1:0] wr_dout;
  logic [DW-1:0] rd_dout;
  logic          busy;
  state_t        state;    // FSM state, exposed for debug and checkers

  modport master (
    output clr, wr_en, wr_addr, rd_addr, wr_din,
    input  wr_dout, rd_dout, busy, state
  );

  modport slave (
    input  clr, wr_en, wr_addr, rd_addr, wr_din,
    output wr_dout, rd_dout, busy, state
  );
endinterface

// File: rtl/bram_dp_core.sv
// bram_dp_core: raw DEPTH x DW array, one write port and two synchronous
// read ports. No reset or bypass so the tools map it onto block RAM.
module bram_dp_core #(
  parameter int DW = 18,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  output logic [DW-1:0] q_a,
  output logic [DW-1:0] q_b
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Write port plus two read-before-write registered read ports.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    q_a <= mem[addr_a];
    q_b <= mem[addr_b];
  end
endmodule

// File: rtl/bram_dp_clr.sv
// bram_dp_clr: simple-dual-port RAM with write-port readback, write-first
// bypass and a hardware zero-fill engine that runs after reset or on clr.
// Optional feature macro: BRAM_OUTREG_EN adds a second output stage (latency 2).
module bram_dp_clr
  import bram_pkg::*;
#(
  parameter int DW = 18,
  parameter int AW = 7
) (
  input  logic         clk,
  input  logic         rst,
  bram_dp_clr_if.slave bus
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;

  logic          wr_acc;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] q_wr, q_rd;

  logic          zero_q, wbyp_q, rbyp_q;
  logic [DW-1:0] din_q;
  logic [DW-1:0] s1_wr, s1_rd;

  // FSM state and clear counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state: the fill walks every address once; clr only restarts from READY.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_CLEAR: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == LAST) state_nx = ST_READY;
      end
      ST_READY: begin
        if (bus.clr) begin
          state_nx = ST_CLEAR;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = ST_CLEAR;
        cnt_nx   = '0;
      end
    endcase
  end

  assign bus.busy  = (state == ST_CLEAR);
  assign bus.state = state;
  assign wr_acc    = !rst && (state == ST_READY) && bus.wr_en;

  // Write mux: clear engine owns the port in CLEAR, user in READY, nobody in reset.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = bus.wr_addr;
    ram_wdata = bus.wr_din;
    if (!rst) begin
      if (state == ST_CLEAR) begin
        ram_we    = 1'b1;
        ram_waddr = cnt;
        ram_wdata = '0;
      end else if (bus.wr_en) begin
        ram_we    = 1'b1;
      end
    end
  end

  bram_dp_core #(.DW(DW), .AW(AW)) u_core (
    .clk    (clk),
    .we     (ram_we),
    .waddr  (ram_waddr),
    .wdata  (ram_wdata),
    .addr_a (bus.wr_addr),
    .addr_b (bus.rd_addr),
    .q_a    (q_wr),
    .q_b    (q_rd)
  );

  // Stage-1 control: zero forcing and per-port write-first bypass decisions.
  always_ff @(posedge clk) begin
    zero_q <= rst || (state == ST_CLEAR);
    wbyp_q <= wr_acc;
    rbyp_q <= wr_acc && (bus.rd_addr == bus.wr_addr);
    din_q  <= bus.wr_din;
  end

  // Stage-1 data is built only from registers, so it is stable between edges.
  assign s1_wr = zero_q ? '0 : (wbyp_q ? din_q : q_wr);
  assign s1_rd = zero_q ? '0 : (rbyp_q ? din_q : q_rd);

`ifdef BRAM_OUTREG_EN
  logic [DW-1:0] s2_wr, s2_rd;

  // Second output stage: carries the stage-1 (already bypassed) value.
  always_ff @(posedge clk) begin
    if (rst || state == ST_CLEAR) begin
      s2_wr <= '0;
      s2_rd <= '0;
    end else begin
      s2_wr <= s1_wr;
      s2_rd <= s1_rd;
    end
  end

  assign bus.wr_dout = s2_wr;
  assign bus.rd_dout = s2_rd;
`else
  assign bus.wr_dout = s1_wr;
  assign bus.rd_dout = s1_rd;
`endif

endmodule

// File: tb/tb_bram_dp_clr.sv
// tb_bram_dp_clr: directed bench for bram_dp_clr at 18x128 and 4x4.
module tb_bram_dp_clr;
  import bram_pkg::*;

  localparam int DW    = 18;
  localparam int AW    = 7;
  localparam int DEPTH = 128;
  localparam int SDW   = 4;
  localparam int SAW   = 2;
  localparam int LAT   = BRAM_RD_LAT;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic rst_s;
  always #5 clk = ~clk;

  bram_dp_clr_if #(.DW(DW),  .AW(AW))  bi ();
  bram_dp_clr_if #(.DW(SDW), .AW(SAW)) si ();

  bram_dp_clr #(.DW(DW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bi)
  );

  bram_dp_clr #(.DW(SDW), .AW(SAW)) dut_s (
    .clk (clk),
    .rst (rst_s),
    .bus (si)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Counts busy cycles on the big instance, optionally pulsing clr at two
  // loop indices, and counts edges where rd_dout was not zero during clear.
  task automatic count_busy(output int n, output int zbad, input int clr_a, input int clr_b);
    n = 0;
    zbad = 0;
    while (bi.busy === 1'b1 && n < 1000) begin
      bi.clr = (n == clr_a || n == clr_b);
      step_n(1);
      bi.clr = 1'b0;
      n++;
      if (bi.rd_dout !== '0) zbad++;
    end
  endtask

  // Reads every address of the big instance against the expected queue.
  task automatic sweep(input string tag, input bit fill);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(fill ? 32'(i + 1) : 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      bi.rd_addr = AW'(i);
      step_n(LAT);
      chk(tag, 32'(bi.rd_dout), exp_q.pop_front());
    end
  endtask

  // ---------------- stimulus ----------------
  int n, zb;

  initial begin
    rst = 1'b1;
    rst_s = 1'b1;
    bi.clr = 1'b0; bi.wr_en = 1'b0; bi.wr_addr = '0; bi.rd_addr = '0; bi.wr_din = '0;
    si.clr = 1'b0; si.wr_en = 1'b0; si.wr_addr = '0; si.rd_addr = '0; si.wr_din = '0;
    step_n(3);

    chk("rst_busy",    32'(bi.busy), 32'd1);
    chk("rst_state",   32'(bi.state), 32'(ST_CLEAR));
    chk("rst_wr_dout", 32'(bi.wr_dout), 32'd0);
    chk("rst_rd_dout", 32'(bi.rd_dout), 32'd0);

    // Power-on clear
    rst = 1'b0;
    count_busy(n, zb, -1, -1);
    chk("init_clr_len",  32'(n), 32'd128);
    chk("init_clr_zero", 32'(zb), 32'd0);
    chk("init_state",    32'(bi.state), 32'(ST_READY));
    sweep("init_sweep", 1'b0);

    // Write then read back on both ports
    bi.wr_en = 1'b1; bi.wr_addr = 7'd5; bi.wr_din = 18'h2ABCD; bi.rd_addr = 7'd0;
    step_n(1);
    bi.wr_en = 1'b0;
    step_n(LAT - 1);
    chk("wr5_readback", 32'(bi.wr_dout), 32'h2ABCD);
    bi.rd_addr = 7'd5;
    step_n(LAT);
    chk("wr5_read", 32'(bi.rd_dout), 32'h2ABCD);

    // Same-edge write/read: bypass must deliver the new data
    bi.wr_en = 1'b1; bi.wr_addr = 7'd9; bi.wr_din = 18'h00011; bi.rd_addr = 7'd9;
    step_n(1);
    bi.wr_en = 1'b0; bi.rd_addr = 7'd0;
    step_n(LAT - 1);
    chk("bypass_rd", 32'(bi.rd_dout), 32'h00011);
    chk("bypass_wr", 32'(bi.wr_dout), 32'h00011);

    // Back-to-back fill with addr+1
    for (int i = 0; i < DEPTH; i++) begin
      bi.wr_en = 1'b1; bi.wr_addr = AW'(i); bi.wr_din = DW'(i + 1);
      step_n(1);
    end
    bi.wr_en = 1'b0;
    sweep("fill_sweep", 1'b1);

    // Runtime clear with writes to address 3 attempted throughout
    bi.rd_addr = 7'd3; bi.clr = 1'b1;
    step_n(1);
    bi.clr = 1'b0;
    bi.wr_en = 1'b1; bi.wr_addr = 7'd3; bi.wr_din = 18'h3FFFF;
    count_busy(n, zb, -1, -1);
    bi.wr_en = 1'b0;
    chk("clr_len",  32'(n), 32'd128);
    chk("clr_zero", 32'(zb), 32'd0);
    sweep("clr_sweep", 1'b0);

    // Reset in the middle of a clear, with clr pulses during the refill
    bi.wr_en = 1'b1; bi.wr_addr = 7'd100; bi.wr_din = 18'h00155;
    step_n(1);
    bi.wr_en = 1'b0;
    bi.clr = 1'b1;
    step_n(1);
    bi.clr = 1'b0;
    step_n(60);
    rst = 1'b1;
    step_n(2);
    chk("midrst_busy",  32'(bi.busy), 32'd1);
    chk("midrst_rdout", 32'(bi.rd_dout), 32'd0);
    rst = 1'b0;
    count_busy(n, zb, 10, 70);
    chk("midrst_len",  32'(n), 32'd128);
    chk("midrst_zero", 32'(zb), 32'd0);
    bi.rd_addr = 7'd100;
    step_n(LAT);
    chk("midrst_a100", 32'(bi.rd_dout), 32'd0);
    bi.rd_addr = 7'd60;
    step_n(LAT);
    chk("midrst_a60", 32'(bi.rd_dout), 32'd0);

    // Small instance: 4-deep clear, latency and no aliasing
    chk("s_rst_busy", 32'(si.busy), 32'd1);
    chk("s_rst_rd",   32'(si.rd_dout), 32'd0);
    rst_s = 1'b0;
    n = 0;
    while (si.busy === 1'b1 && n < 100) begin
      step_n(1);
      n++;
    end
    chk("s_clr_len", 32'(n), 32'd4);
    si.wr_en = 1'b1; si.wr_addr = 2'd3; si.wr_din = 4'h9;
    step_n(1);
    si.wr_en = 1'b0;
    si.rd_addr = 2'd0;
    step_n(LAT);
    chk("s_alias0", 32'(si.rd_dout), 32'd0);
    si.rd_addr = 2'd3;
    step_n(1);
    chk("s_lat_edge1", 32'(si.rd_dout), (LAT == 1) ? 32'h9 : 32'h0);
    step_n(LAT - 1);
    chk("s_read3", 32'(si.rd_dout), 32'h9);
    si.wr_en = 1'b1; si.wr_addr = 2'd0; si.wr_din = 4'h6;
    step_n(1);
    si.wr_en = 1'b0;
    step_n(LAT);
    chk("s_read3_after0", 32'(si.rd_dout), 32'h9);
    si.rd_addr = 2'd0;
    step_n(LAT);
    chk("s_read0", 32'(si.rd_dout), 32'h6);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
